// File: rtl/i8088_bus_target.sv
// Memory/IO target for the demultiplexed 8088 system bus: decodes an aligned
// address window, serves one read or write per ALE, and stretches cycles via READY.
module i8088_bus_target #(
    parameter int                    ADDR_WIDTH  = 20,
    parameter int                    DATA_WIDTH  = 8,
    parameter bit                    IS_IO       = 1'b0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    DEPTH_LOG2  = 10,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ALE,
    input  logic                  IOM,
    input  logic                  RD,
    input  logic                  WR,
    input  logic [ADDR_WIDTH-1:0] Address,
    inout  wire  [DATA_WIDTH-1:0] Data,
    output logic                  READY,
    output logic                  SEL
);

    // state  | meaning
    // IDLE   | no access in progress; waiting for an armed strobe that hits
    // WAIT   | access accepted, READY held low while the counter runs down
    // ACCESS | data phase: read drives Data, write commits once then holds
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    state_t                  state_q, state_nx;
    logic                    armed_q, armed_nx;
    logic                    sel_nx, ready_nx;
    logic [3:0]              cnt_q, cnt_nx;
    logic                    op_wr_q, op_wr_nx;
    logic [DEPTH_LOG2-1:0]   offset_q, offset_nx;
    logic                    rd_oe_q, rd_oe_nx;
    logic                    wr_done_q, wr_done_nx;
    logic                    mem_we;
    logic                    hit;
    logic                    strobe_rd, strobe_wr, strobe_any, held;

    logic [DATA_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

    assign hit = (IOM == !IS_IO) &&
                 (Address[ADDR_WIDTH-1:DEPTH_LOG2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2]);

    assign strobe_rd  = !RD && WR;
    assign strobe_wr  = !WR && RD;
    assign strobe_any = !RD || !WR;
    assign held       = op_wr_q ? !WR : !RD;

    always_comb begin
        state_nx   = state_q;
        armed_nx   = armed_q | ALE;
        sel_nx     = SEL;
        ready_nx   = READY;
        cnt_nx     = cnt_q;
        op_wr_nx   = op_wr_q;
        offset_nx  = offset_q;
        rd_oe_nx   = rd_oe_q;
        wr_done_nx = wr_done_q;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Any strobe consumes the arm, so a miss or an illegal RD+WR
                // still uses up this ALE.
                if (armed_q && strobe_any) begin
                    armed_nx = ALE;
                    if (hit && (strobe_rd || strobe_wr)) begin
                        sel_nx     = 1'b1;
                        op_wr_nx   = strobe_wr;
                        offset_nx  = Address[DEPTH_LOG2-1:0];
                        wr_done_nx = 1'b0;
                        if (WAIT_STATES > 0) begin
                            state_nx = ST_WAIT;
                            cnt_nx   = 4'(WAIT_STATES);
                            ready_nx = 1'b0;
                        end else begin
                            state_nx = ST_ACCESS;
                            rd_oe_nx = strobe_rd;
                        end
                    end
                end
            end

            ST_WAIT: begin
                cnt_nx = cnt_q - 4'd1;
                if (!held) begin
                    state_nx = ST_IDLE;
                    ready_nx = 1'b1;
                    sel_nx   = 1'b0;
                    cnt_nx   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_nx = ST_ACCESS;
                    ready_nx = 1'b1;
                    rd_oe_nx = !op_wr_q;
                end
            end

            ST_ACCESS: begin
                if (op_wr_q && !wr_done_q) begin
                    mem_we     = 1'b1;
                    wr_done_nx = 1'b1;
                end
                if (!held) begin
                    state_nx = ST_IDLE;
                    sel_nx   = 1'b0;
                    rd_oe_nx = 1'b0;
                end
            end

            default: begin
                state_nx = ST_IDLE;
                sel_nx   = 1'b0;
                ready_nx = 1'b1;
                rd_oe_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            SEL       <= 1'b0;
            READY     <= 1'b1;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            offset_q  <= '0;
            rd_oe_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_nx;
            armed_q   <= armed_nx;
            SEL       <= sel_nx;
            READY     <= ready_nx;
            cnt_q     <= cnt_nx;
            op_wr_q   <= op_wr_nx;
            offset_q  <= offset_nx;
            rd_oe_q   <= rd_oe_nx;
            wr_done_q <= wr_done_nx;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (mem_we && !RESET) begin
            mem[offset_q] <= Data;
        end
    end

    // WR gating keeps the target off the bus whenever the CPU is writing.
    assign Data = (rd_oe_q && WR) ? mem[offset_q] : 'z;

endmodule

// File: tb/tb_i8088_bus_target.sv
// Bench for i8088_bus_target: four targets on shared strobes/address, each with
// its own pulled-up data net, checked every cycle against a timing-rule model.
module tb_i8088_bus_target;

    logic        clk = 1'b0;
    logic        rst, ale, iom, rd, wr;
    logic [19:0] addr;
    logic        tb_oe;
    logic [7:0]  tb_val;
    tri1  [7:0]  d0, d1, d2, d3;
    wire  [3:0]  rdy, sel;

    assign d0 = tb_oe ? tb_val : 8'hzz;
    assign d1 = tb_oe ? tb_val : 8'hzz;
    assign d2 = tb_oe ? tb_val : 8'hzz;
    assign d3 = tb_oe ? tb_val : 8'hzz;

    always #5 clk = ~clk;

    localparam int WS   [4] = '{0, 3, 2, 1};
    localparam int DL   [4] = '{10, 10, 10, 2};
    localparam int BASE [4] = '{'h00000, 'h00000, 'h80000, 'h00040};
    localparam bit ISIO [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    i8088_bus_target #(.IS_IO(1'b0), .BASE_ADDR(20'h00000), .DEPTH_LOG2(10), .WAIT_STATES(0)) u0 (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
        .Address(addr), .Data(d0), .READY(rdy[0]), .SEL(sel[0]));
    i8088_bus_target #(.IS_IO(1'b0), .BASE_ADDR(20'h00000), .DEPTH_LOG2(10), .WAIT_STATES(3)) u1 (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
        .Address(addr), .Data(d1), .READY(rdy[1]), .SEL(sel[1]));
    i8088_bus_target #(.IS_IO(1'b0), .BASE_ADDR(20'h80000), .DEPTH_LOG2(10), .WAIT_STATES(2)) u2 (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
        .Address(addr), .Data(d2), .READY(rdy[2]), .SEL(sel[2]));
    i8088_bus_target #(.IS_IO(1'b1), .BASE_ADDR(20'h00040), .DEPTH_LOG2(2), .WAIT_STATES(1)) u3 (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
        .Address(addr), .Data(d3), .READY(rdy[3]), .SEL(sel[3]));

    int total = 0;
    int bad   = 0;

    // Model: an access is a window of edges starting at the accept edge k0.
    int         n_edge = 0;
    bit         m_known = 1'b0;
    bit         m_armed [4];
    bit         m_busy  [4];
    bit         m_isw   [4];
    int         m_k0    [4];
    int         m_off   [4];
    logic [7:0] m_mem   [4][1024];
    bit         m_val   [4][1024];

    function automatic logic [7:0] dget(input int i);
        case (i)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    function automatic bit hit(input int i);
        return (iom == !ISIO[i]) && ((int'(addr) >> DL[i]) == (BASE[i] >> DL[i]));
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    task automatic model_step();
        n_edge++;
        if (rst) begin
            m_known = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_armed[i] = 1'b0;
                m_busy[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                bit any;
                bit held;
                any = !rd || !wr;
                if (!m_busy[i]) begin
                    if (m_armed[i] && any) begin
                        if (hit(i) && (rd != wr)) begin
                            m_busy[i] = 1'b1;
                            m_k0[i]   = n_edge;
                            m_isw[i]  = !wr;
                            m_off[i]  = int'(addr) & ((1 << DL[i]) - 1);
                        end
                        m_armed[i] = ale;
                    end else if (ale) begin
                        m_armed[i] = 1'b1;
                    end
                end else begin
                    held = m_isw[i] ? !wr : !rd;
                    if (ale) m_armed[i] = 1'b1;
                    if (m_isw[i] && (n_edge - m_k0[i]) == WS[i] + 1) begin
                        m_mem[i][m_off[i]] = tb_oe ? tb_val : 8'hFF;
                        m_val[i][m_off[i]] = 1'b1;
                    end
                    if (!held) m_busy[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_model();
        if (!m_known) return;
        for (int i = 0; i < 4; i++) begin
            int m;
            bit e_sel, e_rdy, e_drv;
            m     = n_edge - m_k0[i];
            e_sel = m_busy[i];
            e_rdy = !(m_busy[i] && m < WS[i]);
            e_drv = m_busy[i] && !m_isw[i] && m >= WS[i] && wr;
            chk($sformatf("sel[%0d]@%0d", i, n_edge), int'(sel[i]), int'(e_sel));
            chk($sformatf("ready[%0d]@%0d", i, n_edge), int'(rdy[i]), int'(e_rdy));
            if (!tb_oe) begin
                if (!e_drv)
                    chk($sformatf("released[%0d]@%0d", i, n_edge), int'(dget(i)), 'hFF);
                else if (m_val[i][m_off[i]])
                    chk($sformatf("rdata[%0d]@%0d", i, n_edge), int'(dget(i)), int'(m_mem[i][m_off[i]]));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write_cyc(input bit iom_v, input logic [19:0] a, input logic [7:0] dv,
                             input int hold, input int idx, output int rlow);
        iom = iom_v; addr = a; ale = 1'b1;
        tick();
        ale = 1'b0; wr = 1'b0; tb_oe = 1'b1; tb_val = dv; rlow = 0;
        for (int c = 0; c < hold; c++) begin
            tick();
            if (!rdy[idx]) rlow++;
        end
        wr = 1'b1;
        tick();
        tb_oe = 1'b0;
        tick();
    endtask

    task automatic read_probe(input bit use_ale, input bit iom_v, input logic [19:0] a,
                              input int idx, input int hold, output int lat, output int rlow,
                              output int val, output int selseen, output int rel);
        iom = iom_v; addr = a;
        if (use_ale) begin
            ale = 1'b1;
            tick();
            ale = 1'b0;
        end
        rd = 1'b0; lat = -1; rlow = 0; val = -1; selseen = 0;
        for (int c = 1; c <= hold; c++) begin
            tick();
            if (lat < 0 && dget(idx) != 8'hFF) begin
                lat = c;
                val = int'(dget(idx));
            end
            if (!rdy[idx]) rlow++;
            if (sel[idx]) selseen = 1;
        end
        rd = 1'b1;
        tick();
        rel = (dget(idx) == 8'hFF && !sel[idx]) ? 1 : 0;
        tick();
    endtask

    initial begin
        int lat, rlow, val, ss, rel;
        logic [7:0] wv [6];
        wv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst = 1'b1; ale = 1'b0; iom = 1'b1; rd = 1'b1; wr = 1'b1;
        addr = '0; tb_oe = 1'b0; tb_val = '0;
        repeat (3) tick();
        chk("reset ready", int'(rdy), 'hF);
        chk("reset sel", int'(sel), 0);
        chk("reset data", int'(d0), 'hFF);
        rst = 1'b0;
        tick();

        // Preload, then reset with RD low; storage must survive.
        write_cyc(1'b1, 20'h00005, 8'h3C, 6, 0, rlow);
        rst = 1'b1; rd = 1'b0;
        repeat (5) tick();
        chk("rst+rd data", int'(d0), 'hFF);
        chk("rst+rd ready", int'(rdy[0]), 1);
        chk("rst+rd sel", int'(sel[0]), 0);
        rst = 1'b0; rd = 1'b1;
        tick();
        read_probe(1'b1, 1'b1, 20'h00005, 0, 4, lat, rlow, val, ss, rel);
        chk("preload kept", val, 'h3C);

        // Zero wait states: write then read back.
        write_cyc(1'b1, 20'h00123, 8'hA5, 3, 0, rlow);
        chk("ws0 write ready low", rlow, 0);
        read_probe(1'b1, 1'b1, 20'h00123, 0, 4, lat, rlow, val, ss, rel);
        chk("ws0 read data", val, 'hA5);
        chk("ws0 read latency", lat, 1);
        chk("ws0 read ready low", rlow, 0);
        chk("ws0 release", rel, 1);

        // Three wait states.
        write_cyc(1'b1, 20'h00010, 8'h96, 6, 1, rlow);
        chk("ws3 write ready low", rlow, 3);
        read_probe(1'b1, 1'b1, 20'h00010, 1, 6, lat, rlow, val, ss, rel);
        chk("ws3 ready low", rlow, 3);
        chk("ws3 latency", lat, 4);
        chk("ws3 data", val, 'h96);
        chk("ws3 release", rel, 1);

        // Decode window at 0x80000.
        write_cyc(1'b1, 20'h803FF, 8'h77, 6, 2, rlow);
        read_probe(1'b1, 1'b1, 20'h803FF, 2, 6, lat, rlow, val, ss, rel);
        chk("top of window data", val, 'h77);
        chk("top of window latency", lat, 3);
        chk("top of window ready low", rlow, 2);
        read_probe(1'b1, 1'b1, 20'h80400, 2, 5, lat, rlow, val, ss, rel);
        chk("miss 80400 drive", lat, -1);
        chk("miss 80400 sel", ss, 0);
        chk("miss 80400 ready", rlow, 0);
        read_probe(1'b1, 1'b1, 20'h7FFFF, 2, 5, lat, rlow, val, ss, rel);
        chk("miss 7FFFF drive", lat, -1);
        chk("miss 7FFFF sel", ss, 0);
        read_probe(1'b1, 1'b0, 20'h80000, 2, 5, lat, rlow, val, ss, rel);
        chk("miss io cycle drive", lat, -1);
        chk("miss io cycle sel", ss, 0);

        // Long write with changing data: only the first data-phase edge counts.
        iom = 1'b1; addr = 20'h00200; ale = 1'b1;
        tick();
        ale = 1'b0; wr = 1'b0; tb_oe = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tb_val = wv[k];
            tick();
        end
        wr = 1'b1;
        tick();
        tb_oe = 1'b0;
        tick();
        read_probe(1'b1, 1'b1, 20'h00200, 0, 4, lat, rlow, val, ss, rel);
        chk("long write ws0", val, 'h22);
        read_probe(1'b1, 1'b1, 20'h00200, 1, 6, lat, rlow, val, ss, rel);
        chk("long write ws3", val, 'h55);

        // Strobe with no preceding ALE.
        read_probe(1'b0, 1'b1, 20'h00300, 0, 4, lat, rlow, val, ss, rel);
        chk("no ale drive", lat, -1);
        chk("no ale sel", ss, 0);

        // RD and WR both low.
        iom = 1'b1; addr = 20'h00123; ale = 1'b1;
        tick();
        ale = 1'b0; rd = 1'b0; wr = 1'b0; tb_oe = 1'b1; tb_val = 8'h5F; ss = 0;
        repeat (3) begin
            tick();
            if (sel[0]) ss = 1;
        end
        rd = 1'b1; wr = 1'b1;
        tick();
        tb_oe = 1'b0;
        tick();
        chk("both low sel", ss, 0);
        read_probe(1'b1, 1'b1, 20'h00123, 0, 4, lat, rlow, val, ss, rel);
        chk("both low no write", val, 'hA5);

        // Reset while the ws3 target is waiting: its write is dropped.
        iom = 1'b1; addr = 20'h00010; ale = 1'b1;
        tick();
        ale = 1'b0; wr = 1'b0; tb_oe = 1'b1; tb_val = 8'hE1;
        repeat (2) tick();
        chk("mid wait ready", int'(rdy[1]), 0);
        rst = 1'b1;
        tick();
        chk("reset in wait ready", int'(rdy[1]), 1);
        chk("reset in wait sel", int'(sel[1]), 0);
        rst = 1'b0; wr = 1'b1; tb_oe = 1'b0;
        repeat (2) tick();
        read_probe(1'b1, 1'b1, 20'h00010, 1, 6, lat, rlow, val, ss, rel);
        chk("dropped write ws3", val, 'h96);
        read_probe(1'b1, 1'b1, 20'h00010, 0, 4, lat, rlow, val, ss, rel);
        chk("committed write ws0", val, 'hE1);

        // IO target: OUT then IN, memory cycle to the same address ignored.
        write_cyc(1'b0, 20'h00042, 8'h5A, 4, 3, rlow);
        chk("io write ready low", rlow, 1);
        read_probe(1'b1, 1'b0, 20'h00042, 3, 4, lat, rlow, val, ss, rel);
        chk("io read data", val, 'h5A);
        chk("io read latency", lat, 2);
        chk("io read ready low", rlow, 1);
        chk("io release", rel, 1);
        read_probe(1'b1, 1'b1, 20'h00042, 3, 4, lat, rlow, val, ss, rel);
        chk("io ignores mem drive", lat, -1);
        chk("io ignores mem sel", ss, 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i8088_bus_target.md
Name: i8088_bus_target

Overview:
- Parametrised memory/IO target for the 8088 demultiplexed system bus.
- Connects to the latched 20-bit Address, the transceiver-side Data bus and the processor strobes (ALE, IOM, RD, WR).
- Decodes its address window and serves one read or write per bus cycle.
- Inserts a configurable number of wait states by pulling READY low.
- Several instances, memory or IO, can share one bus in the top-level system.

Parameters:
- ADDR_WIDTH, 20, width of Address input.
- DATA_WIDTH, 8, width of Data bus and storage words.
- IS_IO, 0, 1 = responds only when IOM=0 (IO cycle); 0 = responds only when IOM=1 (memory cycle).
- BASE_ADDR, 20'h00000, first address of the window; must be aligned to 2**DEPTH_LOG2.
- DEPTH_LOG2, 10, log2 of the number of storage words in the window.
- WAIT_STATES, 0, READY-low cycles inserted before data phase (0..15).

Ports:
- CLK  input  1  system clock (rising edge).
- RESET  input  1  synchronous, active-high reset.
- ALE  input  1  address latch enable; high marks the start of a bus cycle.
- IOM  input  1  1 = memory cycle, 0 = IO cycle.
- RD  input  1  read strobe, active low.
- WR  input  1  write strobe, active low.
- Address  input  ADDR_WIDTH  latched bus address, stable from ALE fall to end of cycle.
- Data  inout  DATA_WIDTH  shared data bus; driven only during this target's read data phase, else 'z.
- READY  output  1  0 = insert wait state; 1 otherwise.
- SEL  output  1  registered: current bus cycle is decoded to this target.

Behaviour:
- Reset is sampled on the CLK rising edge; it is synchronous and active-high.
- Reset values: state IDLE, armed=0, SEL=0, READY=1, Data released ('z), wait counter 0. Storage contents are NOT cleared by reset.
- Reset asserted mid-operation: returns to IDLE on that edge and releases Data. A pending write not yet committed is dropped.
- Decode: hit = (IOM == !IS_IO) && (Address[ADDR_WIDTH-1:DEPTH_LOG2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2]).
- Offset = Address[DEPTH_LOG2-1:0]. No wrap: the upper bits must match exactly.
- Arming:
  - Edge with ALE=1 sets armed=1.
  - The first strobe after arming consumes armed.
  - Exactly one access per ALE, however long the strobe is held.
- States:
  - IDLE: when armed && hit && exactly one of RD/WR low, set SEL=1 and capture op/offset.
    - WAIT_STATES>0: go to WAIT, load counter=WAIT_STATES, READY=0 next cycle.
    - WAIT_STATES=0: go to ACCESS directly.
    - RD and WR both low: illegal; no access, stay IDLE, clear armed.
    - Miss: clear armed, stay IDLE, never drive Data or READY low.
  - WAIT:
    - READY=0 each cycle; decrement the counter.
    - When counter reaches 1, go to ACCESS with READY=1.
    - Strobe negated early: abort to IDLE, READY=1, no write.
  - ACCESS:
    - Read: drive Data=mem[offset] from the first ACCESS cycle until RD is sampled high.
    - Write: commit mem[offset]=Data on the first ACCESS edge only, then hold.
    - When the strobe is sampled high, go to IDLE; SEL=0; Data released the same edge.
- Latency:
  - Read data is valid 1 + WAIT_STATES cycles after the edge that samples RD low.
  - READY is low for exactly WAIT_STATES consecutive cycles per hit.
- ALE during WAIT/ACCESS: sets armed for the next cycle; does not disturb the current access.
- Back-to-back cycles: a new strobe may be accepted on the edge after returning to IDLE.
- Data is never driven while WR is low or while the target is not in a read ACCESS state.

Test Plan:
- Reset: RESET=1 for 5 cycles with RD low → Data='z, READY=1, SEL=0; preloaded mem[0x005]=0x3C is still read as 0x3C afterwards.
- Write then read, WAIT_STATES=0, BASE=0x00000:
  - ALE pulse, IOM=1, Address=0x00123, Data=0xA5, WR low for 3 cycles → mem[0x123]=0xA5, READY always 1.
  - Then a read cycle at 0x00123 → Data=0xA5 one cycle after RD sampled low.
- Wait states, WAIT_STATES=3, read 0x00010 → READY low exactly 3 cycles; Data valid on cycle 4; Data 'z on the edge RD rises.
- Decode: BASE=0x80000, DEPTH_LOG2=10, IS_IO=0:
  - Address 0x803FF is a hit.
  - 0x80400 and 0x7FFFF are misses.
  - IOM=0 at 0x80000 is a miss.
  - Misses leave Data='z, READY=1, SEL=0.
- Protocol corners:
  - WR held 6 cycles with a changing Data → only the first ACCESS value is written.
  - Strobe without a preceding ALE → ignored.
  - RD and WR both low → no access.
  - RESET during WAIT → IDLE next edge, write dropped.
- IO instance: IS_IO=1, BASE=0x00040, DEPTH_LOG2=2, WAIT_STATES=1; OUT 0x42=0x5A then IN 0x42 → 0x5A returned; memory cycle at 0x00042 ignored.
